// File: rtl/jpeg_pkg.sv
// Shared JPEG decode-path constants and types used by the inverse level shifter.
package jpeg_pkg;

  localparam int unsigned LEVEL_OFFSET          = 128;
  localparam int unsigned PIXEL_MAX             = 255;
  localparam int unsigned DEFAULT_BLOCK_SAMPLES = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } ils_state_t;

endpackage

// File: rtl/ils_clamp.sv
// Add the level offset to one signed IDCT sample and saturate it to an unsigned 8-bit pixel.
module ils_clamp
  import jpeg_pkg::*;
#(
  parameter int unsigned IN_W = 12
) (
  input  logic signed [IN_W-1:0] x,
  output logic        [7:0]      pixel,
  output logic                   clipped
);

  logic [IN_W:0] s;

  always_comb begin
    s       = {x[IN_W-1], x} + (IN_W+1)'(LEVEL_OFFSET);
    pixel   = s[7:0];
    clipped = 1'b0;
    // s[IN_W] is the sign of the widened sum; once non-negative an unsigned compare is exact
    if (s[IN_W]) begin
      pixel   = '0;
      clipped = 1'b1;
    end else if (s > (IN_W+1)'(PIXEL_MAX)) begin
      pixel   = '1;
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/inverse_level_shifter.sv
// Inverse level shifter: signed IDCT Y/Cb/Cr -> unsigned 8-bit pixels, one block per start.
// Optional clip statistics port enabled by defining ILS_CLIP_STATS_EN.
module inverse_level_shifter
  import jpeg_pkg::*;
#(
  parameter int unsigned IN_W          = 12,
  parameter int unsigned BLOCK_SAMPLES = DEFAULT_BLOCK_SAMPLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] Y_in,
  input  logic signed [IN_W-1:0] Cb_in,
  input  logic signed [IN_W-1:0] Cr_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [7:0]      Y_out,
  output logic        [7:0]      Cb_out,
  output logic        [7:0]      Cr_out,
  output logic                   done
`ifdef ILS_CLIP_STATS_EN
  ,
  output logic        [6:0]      clip_count
`endif
);

  localparam int unsigned CNT_W = $clog2(BLOCK_SAMPLES + 1);

  ils_state_t       state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [7:0]       y_pix, cb_pix, cr_pix;
  logic [2:0]       clip_flags;
  logic             in_hs, out_hs;

  ils_clamp #(.IN_W(IN_W)) u_clamp_y  (.x(Y_in),  .pixel(y_pix),  .clipped(clip_flags[0]));
  ils_clamp #(.IN_W(IN_W)) u_clamp_cb (.x(Cb_in), .pixel(cb_pix), .clipped(clip_flags[1]));
  ils_clamp #(.IN_W(IN_W)) u_clamp_cr (.x(Cr_in), .pixel(cr_pix), .clipped(clip_flags[2]));

`ifndef ILS_CLIP_STATS_EN
  logic clip_unused;
  assign clip_unused = ^clip_flags;
`endif

  always_comb begin
    in_ready = (state == S_RUN) && (in_cnt < CNT_W'(BLOCK_SAMPLES)) && (!out_valid || out_ready);
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
      Y_out      <= '0;
      Cb_out     <= '0;
      Cr_out     <= '0;
      done       <= 1'b0;
`ifdef ILS_CLIP_STATS_EN
      clip_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            in_cnt     <= '0;
            out_cnt    <= '0;
`ifdef ILS_CLIP_STATS_EN
            clip_count <= '0;
`endif
          end
        end
        S_RUN: begin
          // A same-edge input reload keeps out_valid high while the old triple drains
          if (in_hs) begin
            Y_out     <= y_pix;
            Cb_out    <= cb_pix;
            Cr_out    <= cr_pix;
            out_valid <= 1'b1;
            in_cnt    <= in_cnt + 1'b1;
`ifdef ILS_CLIP_STATS_EN
            if (|clip_flags) clip_count <= clip_count + 1'b1;
`endif
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
          if (out_hs) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == CNT_W'(BLOCK_SAMPLES - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_level_shifter.sv
// Directed, table-driven bench for inverse_level_shifter (works with or without ILS_CLIP_STATS_EN).
module tb_inverse_level_shifter;

  localparam int IN_W = 12;
  localparam int BS   = 64;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] Y_in, Cb_in, Cr_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             Y_out, Cb_out, Cr_out;
  logic                   done;
`ifdef ILS_CLIP_STATS_EN
  logic [6:0]             clip_count;
`endif

  inverse_level_shifter #(.IN_W(IN_W), .BLOCK_SAMPLES(BS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y_in(Y_in), .Cb_in(Cb_in), .Cr_in(Cr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y_out(Y_out), .Cb_out(Cb_out), .Cr_out(Cr_out),
    .done(done)
`ifdef ILS_CLIP_STATS_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [IN_W-1:0] y, cb, cr;
    logic [7:0]             ey, ecb, ecr;
    bit                     clip;
  } vec_t;

  vec_t tbl[8];
  vec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_clip;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    q.delete();
    exp_clip = 0;
    #1;
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_done", int'(done), 0);
  endtask

  // mode: 0 nominal constant, 1 table, 2 backpressure, 3 bubbles, 4 stray start
  task automatic run_block(input int mode, input int abort_after);
    int   acc = 0, outs = 0, cyc = 0, dones = 0, idx;
    bit   ihs, ohs, prev_ihs = 0, prev_stall = 0;
    logic [7:0] py = 0, pcb = 0, pcr = 0;
    vec_t e;
    do_start();
    while (outs < BS && cyc < 400) begin
      if (abort_after > 0 && outs == abort_after) return;
      @(negedge clk);
      idx       = (mode == 0) ? 0 : acc % 8;
      start     = (mode == 4 && cyc == 10);
      in_valid  = (mode == 3) ? (cyc % 2 == 0) : 1'b1;
      Y_in      = tbl[idx].y;
      Cb_in     = tbl[idx].cb;
      Cr_in     = tbl[idx].cr;
      out_ready = !(mode == 2 && cyc >= 20 && cyc < 25);
      #1;
      chk("in_ready", int'(in_ready), int'(acc < BS && (!out_valid || out_ready)));
      if (done) dones++;
      if (mode != 2) chk("out_valid_latency", int'(out_valid), int'(prev_ihs));
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_y", int'(Y_out), int'(py));
        chk("hold_cb", int'(Cb_out), int'(pcb));
        chk("hold_cr", int'(Cr_out), int'(pcr));
      end
      ihs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (ohs) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("y_out", int'(Y_out), int'(e.ey));
          chk("cb_out", int'(Cb_out), int'(e.ecb));
          chk("cr_out", int'(Cr_out), int'(e.ecr));
        end
        outs++;
      end
      if (ihs) begin
        q.push_back(tbl[idx]);
        if (tbl[idx].clip) exp_clip++;
        acc++;
      end
      prev_ihs   = ihs;
      prev_stall = out_valid && !out_ready;
      py = Y_out; pcb = Cb_out; pcr = Cr_out;
      cyc++;
    end
    chk("block_outputs", outs, BS);
    chk("block_inputs", acc, BS);
    chk("done_early", dones, 0);
    if (mode == 0 || mode == 1) chk("block_cycles", cyc, BS + 1);
    @(negedge clk); #1;
    chk("done_pulse", int'(done), 1);
    chk("done_out_valid", int'(out_valid), 0);
`ifdef ILS_CLIP_STATS_EN
    chk("clip_count", int'(clip_count), exp_clip);
`endif
    @(negedge clk); #1;
    chk("done_cleared", int'(done), 0);
    chk("idle_in_ready_after", int'(in_ready), 0);
`ifdef ILS_CLIP_STATS_EN
    chk("clip_count_hold", int'(clip_count), exp_clip);
`endif
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("no_second_done", int'(done), 0);
  endtask

  initial begin
    tbl[0] = '{y: -128,  cb: 0,     cr: 127,   ey: 0,   ecb: 128, ecr: 255, clip: 0};
    tbl[1] = '{y: -2048, cb: 2047,  cr: 200,   ey: 0,   ecb: 255, ecr: 255, clip: 1};
    tbl[2] = '{y: -129,  cb: 128,   cr: -1,    ey: 0,   ecb: 255, ecr: 127, clip: 1};
    tbl[3] = '{y: 5,     cb: -5,    cr: 100,   ey: 133, ecb: 123, ecr: 228, clip: 0};
    tbl[4] = '{y: 127,   cb: -128,  cr: 0,     ey: 255, ecb: 0,   ecr: 128, clip: 0};
    tbl[5] = '{y: 128,   cb: -129,  cr: 1,     ey: 255, ecb: 0,   ecr: 129, clip: 1};
    tbl[6] = '{y: -100,  cb: 50,    cr: -50,   ey: 28,  ecb: 178, ecr: 78,  clip: 0};
    tbl[7] = '{y: 2047,  cb: -2048, cr: -2048, ey: 255, ecb: 0,   ecr: 0,   clip: 1};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Y_in = '0; Cb_in = '0; Cr_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(Y_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
`ifdef ILS_CLIP_STATS_EN
    chk("rst_clip_count", int'(clip_count), 0);
`endif
    rst_n = 1'b1;

    run_block(0, 0);
    run_block(1, 0);
    run_block(2, 0);
    run_block(3, 0);
    run_block(4, 0);

    run_block(1, 30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_y", int'(Y_out), 0);
    chk("abort_cb", int'(Cb_out), 0);
    chk("abort_cr", int'(Cr_out), 0);
    chk("abort_done", int'(done), 0);
`ifdef ILS_CLIP_STATS_EN
    chk("abort_clip_count", int'(clip_count), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("abort_no_done", int'(done), 0);
      chk("abort_idle_valid", int'(out_valid), 0);
    end
    run_block(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
